// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, opcode type, default datapath width
// and the result checker's state type.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 8;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD  = 3'b000;
  localparam op_t OP_SUB  = 3'b001;
  localparam op_t OP_AND  = 3'b010;
  localparam op_t OP_OR   = 3'b011;
  localparam op_t OP_XOR  = 3'b100;
  localparam op_t OP_NAND = 3'b101;
  localparam op_t OP_SLT  = 3'b110;
  localparam op_t OP_NOP  = 3'b111;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } chk_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 8-opcode ALU.
// Ports:
//   a, b     - operands
//   op       - opcode (alu_pkg::OP_*)
//   expected - result the ALU must produce
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] expected
);

  logic w_slt;
  assign w_slt = ($signed(a) < $signed(b));

  always_comb begin
    expected = '0;
    case (op)
      OP_ADD:  expected = a + b;
      OP_SUB:  expected = a - b;
      OP_AND:  expected = a & b;
      OP_OR:   expected = a | b;
      OP_XOR:  expected = a ^ b;
      OP_NAND: expected = ~(a & b);
      OP_SLT:  expected = {{(WIDTH-1){1'b0}}, w_slt};
      default: expected = '0;  // NOP
    endcase
  end

endmodule

// File: rtl/alu_result_checker.sv
// Response-side checker for the ALU. Accepts {a, b, op, result} transactions
// in RUN, recomputes the result with alu_ref_model one stage later, and keeps
// saturating pass/fail counters, a first-failure record and a MISR signature.
// Ports:
//   clk, rst          - clock, async active-high reset
//   start, stop       - pulses: clear stats and run / end stream and drain
//   in_valid/in_ready - input handshake (ready only in RUN)
//   a, b, op, result  - transaction under check
//   busy, done        - RUN or DRAIN / DONE level
//   pass_cnt/fail_cnt - saturating match/mismatch counts
//   ff_*              - first mismatch since start
//   signature         - MISR over compared results
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int unsigned      WIDTH     = ALU_WIDTH,
  parameter int unsigned      CNT_W     = 16,
  parameter logic [WIDTH-1:0] MISR_POLY = 8'hB8,
  parameter logic [WIDTH-1:0] MISR_SEED = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  input  logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             ff_valid,
  output logic [WIDTH-1:0] ff_a,
  output logic [WIDTH-1:0] ff_b,
  output op_t              ff_op,
  output logic [WIDTH-1:0] ff_result,
  output logic [WIDTH-1:0] ff_expected,
  output logic [WIDTH-1:0] signature
);

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  chk_state_e r_state;
  logic       r_busy;
  logic       r_done;

  // Compare stage
  logic             r_pv;
  logic [WIDTH-1:0] r_pa;
  logic [WIDTH-1:0] r_pb;
  op_t              r_pop;
  logic [WIDTH-1:0] r_pres;

  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_fail;
  logic             r_ff_valid;
  logic [WIDTH-1:0] r_ff_a;
  logic [WIDTH-1:0] r_ff_b;
  op_t              r_ff_op;
  logic [WIDTH-1:0] r_ff_result;
  logic [WIDTH-1:0] r_ff_expected;
  logic [WIDTH-1:0] r_sig;

  logic             w_run;
  logic             w_accept;
  logic             w_start_go;
  logic [WIDTH-1:0] w_expected;
  logic             w_match;
  logic [WIDTH-1:0] w_sig_next;

  assign w_run      = (r_state == StRun);
  assign w_accept   = in_valid & w_run;
  // Start only takes effect from IDLE/DONE; in IDLE it beats a coincident stop.
  assign w_start_go = start & ((r_state == StIdle) | (r_state == StDone));

  alu_ref_model #(
    .WIDTH(WIDTH)
  ) u_ref (
    .a        (r_pa),
    .b        (r_pb),
    .op       (r_pop),
    .expected (w_expected)
  );

  assign w_match    = (w_expected == r_pres);
  assign w_sig_next = ((r_sig << 1) ^ (r_sig[WIDTH-1] ? MISR_POLY : '0)) ^ r_pres;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_state <= StRun;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        StRun: begin
          if (stop) begin
            r_state <= StDrain;
          end
        end
        // One cycle is enough to retire the single compare stage.
        StDrain: begin
          r_state <= StDone;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pv          <= 1'b0;
      r_pa          <= '0;
      r_pb          <= '0;
      r_pop         <= OP_ADD;
      r_pres        <= '0;
      r_pass        <= '0;
      r_fail        <= '0;
      r_ff_valid    <= 1'b0;
      r_ff_a        <= '0;
      r_ff_b        <= '0;
      r_ff_op       <= OP_ADD;
      r_ff_result   <= '0;
      r_ff_expected <= '0;
      r_sig         <= MISR_SEED;
    end else if (w_start_go) begin
      r_pv          <= 1'b0;
      r_pass        <= '0;
      r_fail        <= '0;
      r_ff_valid    <= 1'b0;
      r_ff_a        <= '0;
      r_ff_b        <= '0;
      r_ff_op       <= OP_ADD;
      r_ff_result   <= '0;
      r_ff_expected <= '0;
      r_sig         <= MISR_SEED;
    end else begin
      r_pv <= w_accept;
      if (w_accept) begin
        r_pa   <= a;
        r_pb   <= b;
        r_pop  <= op;
        r_pres <= result;
      end
      if (r_pv) begin
        r_sig <= w_sig_next;
        if (w_match) begin
          if (r_pass != CntMax) r_pass <= r_pass + CntOne;
        end else begin
          if (r_fail != CntMax) r_fail <= r_fail + CntOne;
          if (!r_ff_valid) begin
            r_ff_valid    <= 1'b1;
            r_ff_a        <= r_pa;
            r_ff_b        <= r_pb;
            r_ff_op       <= r_pop;
            r_ff_result   <= r_pres;
            r_ff_expected <= w_expected;
          end
        end
      end
    end
  end

  assign in_ready    = w_run;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass_cnt    = r_pass;
  assign fail_cnt    = r_fail;
  assign ff_valid    = r_ff_valid;
  assign ff_a        = r_ff_a;
  assign ff_b        = r_ff_b;
  assign ff_op       = r_ff_op;
  assign ff_result   = r_ff_result;
  assign ff_expected = r_ff_expected;
  assign signature   = r_sig;

endmodule

// File: tb/tb_alu_result_checker.sv
module tb_alu_result_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] op = '0;
  logic [7:0] result = '0;

  logic        in_ready, busy, done, ff_valid;
  logic [15:0] pass_cnt, fail_cnt;
  logic [7:0]  ff_a, ff_b, ff_result, ff_expected, signature;
  logic [2:0]  ff_op;

  logic        s_in_ready, s_busy, s_done, s_ff_valid;
  logic [3:0]  s_pass_cnt, s_fail_cnt;
  logic [7:0]  s_ff_a, s_ff_b, s_ff_result, s_ff_expected, s_signature;
  logic [2:0]  s_ff_op;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_result_checker u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .result(result),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .ff_valid(ff_valid), .ff_a(ff_a), .ff_b(ff_b), .ff_op(ff_op),
    .ff_result(ff_result), .ff_expected(ff_expected), .signature(signature)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  alu_result_checker #(.CNT_W(4)) u_dut_sat (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .op(op), .result(result),
    .busy(s_busy), .done(s_done), .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt),
    .ff_valid(s_ff_valid), .ff_a(s_ff_a), .ff_b(s_ff_b), .ff_op(s_ff_op),
    .ff_result(s_ff_result), .ff_expected(s_ff_expected), .signature(s_signature)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] top,
                      input logic [7:0] tres);
    a = ta; b = tb; op = top; result = tres; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic stop_and_drain();
    stop = 1'b1; tick(); stop = 1'b0;
    tick();
  endtask

  function automatic logic [7:0] misr(input logic [7:0] s, input logic [7:0] r);
    return ((s << 1) ^ (s[7] ? 8'hB8 : 8'h00)) ^ r;
  endfunction

  logic [7:0] hp_res [8];
  logic [7:0] exp_sig;

  initial begin
    hp_res[0] = 8'h0D; hp_res[1] = 8'h07; hp_res[2] = 8'h02; hp_res[3] = 8'h0B;
    hp_res[4] = 8'h09; hp_res[5] = 8'hFD; hp_res[6] = 8'h01; hp_res[7] = 8'h00;

    // 1. Async reset before any clock edge
    #1 rst = 1'b1;
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass_cnt, 0);
    check("rst_fail", fail_cnt, 0);
    check("rst_ff_valid", ff_valid, 0);
    check("rst_sig", signature, 8'h00);
    #1 rst = 1'b0;
    tick();

    // in_valid while IDLE is dropped
    send(8'h0A, 8'h03, 3'b000, 8'h55);
    tick(); tick();
    check("idle_drop_pass", pass_cnt, 0);
    check("idle_drop_fail", fail_cnt, 0);
    check("idle_drop_sig", signature, 8'h00);

    // 2. Happy path over all opcodes
    pulse_start();
    check("run_ready", in_ready, 1);
    check("run_busy", busy, 1);
    exp_sig = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send(8'h0A, (i == 6) ? 8'h0F : 8'h03, 3'(i), hp_res[i]);
      exp_sig = misr(exp_sig, hp_res[i]);
    end
    stop_and_drain();
    check("hp_done", done, 1);
    check("hp_busy", busy, 0);
    check("hp_ready", in_ready, 0);
    check("hp_pass", pass_cnt, 8);
    check("hp_fail", fail_cnt, 0);
    check("hp_ff_valid", ff_valid, 0);
    check("hp_sig", signature, exp_sig);

    // 3. First-fail capture; second failure arrives with stop
    pulse_start();
    check("restart_pass", pass_cnt, 0);
    send(8'h0A, 8'h03, 3'b000, 8'h0C);
    tick();
    check("ff1_fail", fail_cnt, 1);
    check("ff1_valid", ff_valid, 1);
    check("ff1_result", ff_result, 8'h0C);
    check("ff1_expected", ff_expected, 8'h0D);
    check("ff1_a", ff_a, 8'h0A);
    check("ff1_b", ff_b, 8'h03);
    check("ff1_op", ff_op, 3'b000);
    a = 8'h0A; b = 8'h03; op = 3'b100; result = 8'h00; in_valid = 1'b1; stop = 1'b1;
    tick();
    in_valid = 1'b0; stop = 1'b0;
    tick();
    check("ff2_done", done, 1);
    check("ff2_fail", fail_cnt, 2);
    check("ff2_pass", pass_cnt, 0);
    check("ff2_result", ff_result, 8'h0C);
    check("ff2_expected", ff_expected, 8'h0D);
    check("ff2_op", ff_op, 3'b000);

    // 4. Signed SLT
    pulse_start();
    check("slt_ff_cleared", ff_valid, 0);
    send(8'h80, 8'h01, 3'b110, 8'h01);
    send(8'h80, 8'h01, 3'b110, 8'h00);
    tick();
    check("slt_pass", pass_cnt, 1);
    check("slt_fail", fail_cnt, 1);
    check("slt_ff_expected", ff_expected, 8'h01);
    check("slt_ff_result", ff_result, 8'h00);
    check("slt_ff_a", ff_a, 8'h80);
    stop_and_drain();

    // in_valid in DONE is dropped and outputs hold
    send(8'h0A, 8'h03, 3'b000, 8'h99);
    tick();
    check("done_hold_pass", pass_cnt, 1);
    check("done_hold_fail", fail_cnt, 1);
    check("done_hold_done", done, 1);

    // 5. Signature steps
    pulse_start();
    check("sig_seed", signature, 8'h00);
    send(8'h0A, 8'h03, 3'b000, 8'h0D);
    tick();
    check("sig_step1", signature, 8'h0D);
    send(8'h0A, 8'h03, 3'b001, 8'h07);
    tick();
    check("sig_step2", signature, 8'h1D);
    stop_and_drain();

    // 6a. Saturation on the narrow instance
    pulse_start();
    a = 8'h0A; b = 8'h03; op = 3'b000; result = 8'h0D; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    in_valid = 1'b0;
    tick();
    check("sat_pass4", s_pass_cnt, 15);
    check("sat_fail4", s_fail_cnt, 0);
    check("wide_pass", pass_cnt, 20);

    // 6b. Reset mid-RUN, with a transaction sitting in the compare stage
    send(8'h0A, 8'h03, 3'b000, 8'h0D);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_pass", pass_cnt, 0);
    check("mid_rst_sat_pass", s_pass_cnt, 0);
    check("mid_rst_sig", signature, 8'h00);
    rst = 1'b0;
    tick();
    check("post_rst_pass", pass_cnt, 0);
    check("post_rst_busy", busy, 0);

    // 6c. start and stop together in IDLE: start wins
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("ss_ready", in_ready, 1);
    check("ss_busy", busy, 1);
    tick();
    check("ss_still_run", in_ready, 1);
    check("ss_done", done, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
- Synthesizable response-side companion to the 8-bit ALU. It consumes {a, b, op, result} transactions from the stimulus side through a valid/ready handshake.
- For each transaction it recomputes the expected result with a golden model and compares it against the received result.
- It keeps pass/fail counters, captures the first mismatch, and compacts all received results into a MISR signature.
- Used as on-chip self-check for ALU bring-up, and as the scoreboard end of the ALU test environment.

Parameters:
- WIDTH, 8, operand/result width
- CNT_W, 16, width of pass/fail counters (saturating)
- MISR_POLY, 8'hB8, MISR feedback taps (WIDTH bits)
- MISR_SEED, 8'h00, MISR value after reset/start

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse: clear stats, enter RUN
- stop  in  1  pulse: end of stream, drain and enter DONE
- in_valid  in  1  transaction present
- in_ready  out  1  checker accepts (high only in RUN)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  opcode
- result  in  WIDTH  DUT result under check
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE (level)
- pass_cnt  out  CNT_W  matching transactions
- fail_cnt  out  CNT_W  mismatching transactions
- ff_valid  out  1  first-fail record holds data
- ff_a, ff_b  out  WIDTH  operands of first failure
- ff_op  out  3  opcode of first failure
- ff_result, ff_expected  out  WIDTH  received/expected values of first failure
- signature  out  WIDTH  MISR over accepted results

Behaviour:
- Reset (async, immediate, no clock needed): state IDLE; all outputs 0 except signature=MISR_SEED; pipeline valid cleared.
- Opcodes:
  - 000 ADD a+b mod 2^W
  - 001 SUB a-b mod 2^W
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NAND ~(a&b)
  - 110 SLT: signed compare; result 1 if $signed(a)<$signed(b), else 0 (zero-extended)
  - 111 NOP: expected 0
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE/DONE + start -> RUN. On that edge: counters=0, ff_*=0, ff_valid=0, signature=MISR_SEED.
  - RUN + stop -> DRAIN. Start is ignored in RUN; if start and stop arrive together in RUN, stop wins.
  - DRAIN -> DONE unconditionally after 1 cycle, which retires the compare stage.
  - IDLE + start&stop together: start wins (-> RUN).
  - stop outside RUN is ignored.
- in_ready = (state==RUN), combinational from state. No backpressure within RUN.
- Accept = in_valid & in_ready.
  - Accepted inputs are registered into a 1-stage compare pipeline on the accept edge.
  - The compare result updates counters/signature/ff on the next edge, so stats are visible 2 edges after accept.
  - On the transaction accepted the same cycle stop is seen: accepted, and counted during DRAIN.
- in_valid while not RUN: dropped, no stat change.
- Counters saturate at 2^CNT_W-1; no wrap.
- First fail: on the first mismatch since start, capture a,b,op,result,expected and set ff_valid. Later mismatches only increment fail_cnt.
- MISR, per compared transaction: sig <= ((sig<<1) ^ (sig[W-1] ? MISR_POLY : 0)) ^ result.
- Outputs hold their values in DONE until the next start or rst.

Decomposition:
- Package alu_pkg: opcode localparams (OP_ADD..OP_NOP), 3-bit op type, default WIDTH.
- Sub-module alu_ref_model: purely combinational golden model (a, b, op -> expected). It is shared with other ALU benches.
- Checker FSM, counters and MISR live in alu_result_checker.

Test Plan:
1. Reset: assert rst with no clock -> in_ready=0, busy=0, done=0, counters=0, ff_valid=0, signature=8'h00.
2. Happy path: start, then 8 txns with a=0A and b=03 for all except SLT (b=0F), op 000..111, results 0D,07,02,0B,09,FD,01,00; then stop -> done=1, pass_cnt=8, fail_cnt=0, ff_valid=0.
3. Fault capture:
   - ADD 0A+03 with result 0C -> fail_cnt=1, ff_valid=1, ff_result=0C, ff_expected=0D.
   - Then XOR result 00 -> fail_cnt=2, ff_* unchanged.
4. Signed SLT:
   - a=80, b=01, result=01 -> pass.
   - Same operands with result=00 -> fail, ff_expected=01.
5. Signature: seed 00, results 0D then 07 -> signature 0D after first compare, 1D after second. in_valid pulsed in IDLE -> no change.
6. Boundaries:
   - CNT_W=4 override, 20 passing txns -> pass_cnt=15.
   - rst asserted mid-RUN -> immediate IDLE and all cleared.
   - start+stop together in IDLE -> RUN.
